// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect and decode handoff.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IADDR = 10
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [IADDR-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             dec_valid;
  logic             dec_ready;
  logic [WIDTH-1:0] dec_instr;
  logic [WIDTH-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited pipelined imem requests, DEPTH-entry word buffer,
// redirect flush with stale-response dropping. Optional perf counters under `FETCH_PERF_EN.
module fetch_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IADDR = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init_pc,
  fetch_unit_if.master     bus,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_redirect_cnt
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] buf_instr [DEPTH];
  logic [WIDTH-1:0] buf_pc    [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    inflight_next;
  logic [CW:0]      occupancy;
  logic             redirect;
  logic             req_fire;
  logic             push;
  logic             pop;

  always_comb begin
    redirect           = bus.redirect_valid;
    occupancy          = {1'b0, inflight} + {1'b0, count};
    bus.imem_req_valid = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
    bus.imem_req_addr  = pc[IADDR-1:0];
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    push               = bus.imem_rsp_valid && (drop == '0) && !redirect;
    pop                = (count != '0) && bus.dec_ready && !redirect;
    inflight_next      = inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    bus.dec_valid      = (count != '0);
    bus.dec_instr      = buf_instr[rd_ptr];
    bus.dec_pc         = buf_pc[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= init_pc & ~WIDTH'(3);
      rsp_pc   <= init_pc & ~WIDTH'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        pc     <= bus.redirect_pc & ~WIDTH'(3);
        rsp_pc <= bus.redirect_pc & ~WIDTH'(3);
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // Every outstanding response is stale now, including ones an earlier redirect already doomed.
        drop   <= inflight_next;
      end else begin
        if (req_fire)
          pc <= pc + WIDTH'(4);
        if (bus.imem_rsp_valid && (drop != '0))
          drop <= drop - 1'b1;
        if (push) begin
          rsp_pc <= rsp_pc + WIDTH'(4);
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        assert (!(push && !pop && (count == CW'(DEPTH))));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_instr[wr_ptr] <= bus.imem_rsp_data;
      buf_pc[wr_ptr]    <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (bus.dec_ready && (count == '0) && !redirect && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (redirect && (redir_q != '1))
        redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_stall_cnt    = stall_q;
  assign perf_redirect_cnt = redir_q;
`else
  assign perf_stall_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: variable-latency in-order memory model, expected words queued
// at response time and compared at decode pop; request credit/address checked every cycle.
module tb_fetch_unit;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IADDR = 10;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] init_pc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;

  fetch_unit_if #(.WIDTH(WIDTH), .IADDR(IADDR)) bus ();

  fetch_unit #(.WIDTH(WIDTH), .IADDR(IADDR), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .init_pc           (init_pc),
    .bus               (bus.master),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IADDR-1:0] addr;
    logic [31:0]      pc;
    int               due;
    bit               live;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend[$];
  ent_t        exp_q[$];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          fires = 0;
  int          pops = 0;
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          last_due = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_pop_pc = '0;

  function automatic logic [31:0] mem_word(input logic [IADDR-1:0] a);
    return ({22'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance the reference model.
  task automatic cycle();
    bit   redir;
    bit   exp_rv;
    ent_t e;
    req_t r;
    int   lat;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    if (reset) begin
      check_eq("req_valid_in_reset", 32'(bus.imem_req_valid), 32'd0);
    end else begin
      redir  = bus.redirect_valid;
      exp_rv = !redir && (pend.size() + exp_q.size() < DEPTH);
      check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (bus.imem_req_valid)
        check_eq("req_addr", 32'(bus.imem_req_addr), 32'(exp_pc[IADDR-1:0]));
      check_eq("dec_valid", 32'(bus.dec_valid), 32'(exp_q.size() != 0));
      if (bus.dec_valid && bus.dec_ready && !redir && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("dec_pc", bus.dec_pc, e.pc);
        check_eq("dec_instr", bus.dec_instr, e.instr);
        last_pop_pc = bus.dec_pc;
        pops++;
      end
      if (redir) begin
        exp_q.delete();
        foreach (pend[i]) pend[i].live = 1'b0;
      end
      if (bus.imem_rsp_valid) begin
        r = pend.pop_front();
        if (r.live) begin
          e.pc    = r.pc;
          e.instr = mem_word(r.pc[IADDR-1:0]);
          exp_q.push_back(e);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        lat    = int'($urandom_range(lat_max, lat_min));
        r.addr = bus.imem_req_addr;
        r.pc   = exp_pc;
        r.live = 1'b1;
        r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        exp_pc = exp_pc + 32'd4;
        fires++;
      end
      if (redir)
        exp_pc = bus.redirect_pc & ~32'h3;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] ipc);
    reset              = 1'b1;
    init_pc            = ipc;
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    pend.delete();
    exp_q.delete();
    repeat (2) cycle();
    reset  = 1'b0;
    exp_pc = ipc & ~32'h3;
  endtask

  task automatic wait_pop(input int max, input string tag);
    int p0 = pops;
    int n  = 0;
    while (pops == p0 && n < max) begin
      cycle();
      n++;
    end
    check_eq({tag, "_pop_timeout"}, 32'(pops != p0), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    int f0;
    int p0;
    int n;
    reset              = 1'b1;
    init_pc            = 32'h100;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    @(negedge clk);

    // 1: streaming at one instruction per cycle
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(32'h100);
    check_eq("t1_reset_dec_valid", 32'(bus.dec_valid), 32'd0);
    check_eq("t1_first_addr", 32'(bus.imem_req_addr), 32'h100);
    bus.dec_ready = 1'b1;
    repeat (3) cycle();
    check_eq("t1_first_pop_pc", last_pop_pc, 32'h100);
    p0 = pops;
    repeat (8) cycle();
    check_eq("t1_throughput", 32'(pops - p0), 32'd8);
    check_eq("t1_perf_off_or_counting", 32'(perf_redirect_cnt), 32'd0);

    // 2: credit limit with decode stalled
    do_reset(32'h100);
    f0 = fires;
    repeat (12) cycle();
    check_eq("t2_req_count", 32'(fires - f0), DEPTH);
    #1;
    check_eq("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    bus.dec_ready = 1'b1;
    p0 = pops;
    repeat (4) cycle();
    check_eq("t2_drain_pops", 32'(pops - p0), 32'd4);
    check_eq("t2_last_pc", last_pop_pc, 32'h10C);
    f0 = fires;
    repeat (4) cycle();
    check_eq("t2_resumed", 32'(fires > f0), 32'd1);

    // 3: redirect with two requests in flight at latency 3
    lat_min = 3; lat_max = 3;
    do_reset(32'h100);
    bus.dec_ready = 1'b1;
    n = 0;
    while (pend.size() != 2 && n < 20) begin
      cycle();
      n++;
    end
    check_eq("t3_inflight", 32'(pend.size()), 32'd2);
    redirect_to(32'h200);
    wait_pop(20, "t3");
    check_eq("t3_first_pc", last_pop_pc, 32'h200);
    repeat (10) cycle();

    // 4: unaligned target, then back-to-back redirects
    lat_min = 1; lat_max = 1;
    redirect_to(32'h203);
    #1;
    check_eq("t4_aligned_addr", 32'(bus.imem_req_addr), 32'h200);
    wait_pop(20, "t4a");
    check_eq("t4_aligned_pc", last_pop_pc, 32'h200);
    redirect_to(32'h300);
    redirect_to(32'h404);
    wait_pop(20, "t4b");
    check_eq("t4_last_wins", last_pop_pc, 32'h404);

    // 5: random ready/latency/redirects, including a wrapping PC target
    rdy_pct = 60; lat_min = 1; lat_max = 4;
    do_reset(32'h101);
    for (int i = 0; i < 500; i++) begin
      bus.dec_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 3) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = (i == 250) ? 32'hFFFF_FFF6 : $urandom();
      end else begin
        bus.redirect_valid = 1'b0;
      end
      cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b1;
    repeat (30) cycle();
    check_eq("t5_progress", 32'(pops > 100), 32'd1);

    // 6: performance counters
`ifdef FETCH_PERF_EN
    rdy_pct = 0;
    do_reset(32'h100);
    bus.dec_ready = 1'b1;
    repeat (5) cycle();
    bus.dec_ready = 1'b0;
    redirect_to(32'h200);
    redirect_to(32'h300);
    cycle();
    check_eq("t6_stall_cnt", perf_stall_cnt, 32'd5);
    check_eq("t6_redirect_cnt", perf_redirect_cnt, 32'd2);
    do_reset(32'h100);
    check_eq("t6_stall_reset", perf_stall_cnt, 32'd0);
    check_eq("t6_redirect_reset", perf_redirect_cnt, 32'd0);
`else
    check_eq("t6_stall_tied", perf_stall_cnt, 32'd0);
    check_eq("t6_redirect_tied", perf_redirect_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
